// File: rtl/binary_gcd_param_if.sv
// Handshake and data bundle for the binary GCD engine.
// The master side drives the operands and controls. The slave side
// returns the working registers, the result, the counters and the state bits.
interface binary_gcd_param_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1),
    parameter int CYC_W = 16
);
    logic             SCEN;
    logic             Start;
    logic             Ack;
    logic [WIDTH-1:0] Ain;
    logic [WIDTH-1:0] Bin;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] AB_GCD;
    logic [CNT_W-1:0] i_count;
    logic [CYC_W-1:0] Cycles;
    logic             Zero_err;
    logic             q_I;
    logic             q_Sub;
    logic             q_Mult;
    logic             q_Done;

    modport master (
        output SCEN, Start, Ack, Ain, Bin,
        input  A, B, AB_GCD, i_count, Cycles, Zero_err,
        input  q_I, q_Sub, q_Mult, q_Done
    );

    modport slave (
        input  SCEN, Start, Ack, Ain, Bin,
        output A, B, AB_GCD, i_count, Cycles, Zero_err,
        output q_I, q_Sub, q_Mult, q_Done
    );
endinterface

// File: rtl/binary_gcd_param.sv
// Parametrised binary (Stein) GCD engine.
// SUB removes common factors of 2 and reduces the operands by subtraction.
// MULT restores the common factors of 2 into the result.
// All outputs come straight from registers.
module binary_gcd_param #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1),
    parameter int CYC_W = 16
) (
    input  logic                Clk,
    input  logic                Reset,
    binary_gcd_param_if.slave   bus
);
    // One-hot state encoding. The state bits are also the q_* outputs.
    localparam logic [3:0] ST_INI  = 4'b0001;
    localparam logic [3:0] ST_SUB  = 4'b0010;
    localparam logic [3:0] ST_MULT = 4'b0100;
    localparam logic [3:0] ST_DONE = 4'b1000;

    logic [3:0]       state;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] gcd_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CYC_W-1:0] cyc_r;
    logic             zerr_r;
    logic [CYC_W-1:0] cyc_inc;

    // Saturating step count, used by every enabled SUB/MULT step
    always_comb begin
        cyc_inc = (cyc_r == '1) ? cyc_r : cyc_r + CYC_W'(1);
    end

    // State machine and datapath registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state  <= ST_INI;
            a_r    <= '0;
            b_r    <= '0;
            gcd_r  <= '0;
            cnt_r  <= '0;
            cyc_r  <= '0;
            zerr_r <= 1'b0;
        end else begin
            case (state)
                ST_INI: begin
                    a_r    <= bus.Ain;
                    b_r    <= bus.Bin;
                    gcd_r  <= '0;
                    cnt_r  <= '0;
                    cyc_r  <= '0;
                    zerr_r <= 1'b0;
                    if (bus.Start) begin
                        if ((bus.Ain == '0) || (bus.Bin == '0)) begin
                            state  <= ST_DONE;
                            gcd_r  <= bus.Ain | bus.Bin;
                            zerr_r <= (bus.Ain == '0) && (bus.Bin == '0);
                        end else begin
                            state <= ST_SUB;
                        end
                    end
                end
                ST_SUB: begin
                    if (bus.SCEN) begin
                        cyc_r <= cyc_inc;
                        if (a_r == b_r) begin
                            gcd_r <= a_r;
                            state <= (cnt_r != '0) ? ST_MULT : ST_DONE;
                        end else if (a_r < b_r) begin
                            a_r <= b_r;
                            b_r <= a_r;
                        end else if (!a_r[0] && !b_r[0]) begin
                            a_r   <= a_r >> 1;
                            b_r   <= b_r >> 1;
                            cnt_r <= cnt_r + CNT_W'(1);
                        end else if (a_r[0] && !b_r[0]) begin
                            b_r <= b_r >> 1;
                        end else if (!a_r[0] && b_r[0]) begin
                            a_r <= a_r >> 1;
                        end else begin
                            a_r <= a_r - b_r;
                        end
                    end
                end
                ST_MULT: begin
                    if (bus.SCEN) begin
                        cyc_r <= cyc_inc;
                        gcd_r <= gcd_r << 1;
                        cnt_r <= cnt_r - CNT_W'(1);
                        if (cnt_r == CNT_W'(1)) begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (bus.Ack) begin
                        state <= ST_INI;
                    end
                end
                default: begin
                    state  <= ST_INI;
                    a_r    <= '0;
                    b_r    <= '0;
                    gcd_r  <= '0;
                    cnt_r  <= '0;
                    cyc_r  <= '0;
                    zerr_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.A        = a_r;
    assign bus.B        = b_r;
    assign bus.AB_GCD   = gcd_r;
    assign bus.i_count  = cnt_r;
    assign bus.Cycles   = cyc_r;
    assign bus.Zero_err = zerr_r;
    assign bus.q_I      = state[0];
    assign bus.q_Sub    = state[1];
    assign bus.q_Mult   = state[2];
    assign bus.q_Done   = state[3];
endmodule
